// File: rtl/counter_pkg.sv
// Shared types, constants and helpers for the up/down tick counter.
package counter_pkg;

  // Values of i_sat
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Value of i_up that selects counting upward
  localparam logic DIR_UP = 1'b1;

  // Number of decimal digits needed to print max (at least one).
  function automatic int f_digits(input int max);
    int v;
    int d;
    v = max;
    d = 1;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/updown_counter_tick_tick_gen.sv
// Prescaler: produces a single-cycle step enable every TICK_DIV running
// cycles. Holds while i_run is low; i_clear restarts the period.
module cnt_tick_gen
  import counter_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_step
);

  localparam int              PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   LC_TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;

  // The step fires on the last prescaler state so the count updates on that edge.
  assign o_step = i_run && (r_pre == LC_TOP);

  // Prescaler state: restart on clear, advance only while running.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
    end else if (i_run) begin
      r_pre <= (r_pre == LC_TOP) ? '0 : r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_tick.sv
// Up/down counter 0..MAX_COUNT stepped by an internal prescaler enable.
// Wrap or saturate at the limits, synchronous clear/load, registered
// step/wrap pulses. Optional build macro COUNTER_BCD_EN adds a sequential
// binary-to-BCD converter on o_count.
module updown_counter_tick
  import counter_pkg::*;
#(
  parameter int  TICK_DIV  = 1_000_000,
  parameter int  MAX_COUNT = 9999,
  localparam int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_run,
  input  logic         i_clear,
  input  logic         i_up,
  input  logic         i_sat,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  output logic [W-1:0] o_count,
  output logic         o_tick,
  output logic         o_wrap,
`ifdef COUNTER_BCD_EN
  output logic [4*f_digits(MAX_COUNT)-1:0] o_bcd,
  output logic                             o_bcd_valid,
`endif
  output logic         o_at_limit
);

  localparam logic [W-1:0] LC_MAX = W'(MAX_COUNT);

  logic [W-1:0] r_count;
  logic         r_tick;
  logic         r_wrap;
  logic [W-1:0] w_count_nxt;
  logic         w_tick_nxt;
  logic         w_wrap_nxt;
  logic         w_step;

  // Clear and load both restart the prescaler period.
  cnt_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_run  (i_run),
    .i_clear(i_clear | i_load),
    .o_step (w_step)
  );

  // Next count and pulses: clear beats load, load beats step (load suppresses pulses).
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (i_load) begin
      w_count_nxt = (i_load_data > LC_MAX) ? LC_MAX : i_load_data;
    end else if (w_step) begin
      w_tick_nxt = 1'b1;
      if (i_up == DIR_UP) begin
        if (r_count != LC_MAX) begin
          w_count_nxt = r_count + 1'b1;
        end else if (i_sat != MODE_SAT) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_count_nxt = r_count - 1'b1;
        end else if (i_sat == MODE_WRAP) begin
          w_count_nxt = LC_MAX;
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // Count and status pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign o_count    = r_count;
  assign o_tick     = r_tick;
  assign o_wrap     = r_wrap;
  assign o_at_limit = ((i_up == DIR_UP) && (r_count == LC_MAX)) ||
                      ((i_up != DIR_UP) && (r_count == '0));

`ifdef COUNTER_BCD_EN
  localparam int D  = f_digits(MAX_COUNT);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   r_count_q;
  logic [W-1:0]   r_bin;
  logic [4*D-1:0] r_work;
  logic [4*D-1:0] r_bcd;
  logic [CW-1:0]  r_bits;
  logic           r_busy;
  logic           r_bcd_valid;
  logic [4*D-1:0] w_adj;
  logic [4*D-1:0] w_shift;

  // One shift-add-3 iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < D; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj[4*D-2:0], r_bin[W-1]};
  end

  // Converter control: any change of o_count (re)starts a W-cycle conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count_q   <= '0;
      r_bin       <= '0;
      r_work      <= '0;
      r_bcd       <= '0;
      r_bits      <= '0;
      r_busy      <= 1'b0;
      r_bcd_valid <= 1'b1;
    end else begin
      r_count_q <= r_count;
      if (r_count != r_count_q) begin
        r_bin       <= r_count;
        r_work      <= '0;
        r_bits      <= CW'(W);
        r_busy      <= 1'b1;
        r_bcd_valid <= 1'b0;
      end else if (r_busy) begin
        r_work <= w_shift;
        r_bin  <= {r_bin[W-2:0], 1'b0};
        r_bits <= r_bits - 1'b1;
        if (r_bits == CW'(1)) begin
          r_bcd       <= w_shift;
          r_busy      <= 1'b0;
          r_bcd_valid <= 1'b1;
        end
      end
    end
  end

  assign o_bcd       = r_bcd;
  assign o_bcd_valid = r_bcd_valid;
`endif

endmodule

// File: tb/tb_updown_counter_tick.sv
// Self-checking bench for updown_counter_tick (TICK_DIV=4, MAX_COUNT=9).
// A reference model pushes the expected count/pulses per cycle into a
// scoreboard queue; entries are popped and compared after each clock edge.
module tb_updown_counter_tick;

  localparam int TD   = 4;
  localparam int MAXC = 9;

  typedef struct packed {
    logic [3:0] count;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run, clear, up, sat, load;
  logic [3:0] ldata;
  logic [3:0] count;
  logic       tick, wrap, at_limit;

  exp_t q[$];
  int   n_checks;
  int   n_err;
  int   m_pre;
  int   m_count;
  int   n_tick_seen;
  int   n_wrap_seen;

  updown_counter_tick #(
    .TICK_DIV (TD),
    .MAX_COUNT(MAXC)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .i_run      (run),
    .i_clear    (clear),
    .i_up       (up),
    .i_sat      (sat),
    .i_load     (load),
    .i_load_data(ldata),
    .o_count    (count),
    .o_tick     (tick),
    .o_wrap     (wrap),
`ifdef COUNTER_BCD_EN
    .o_bcd      (),
    .o_bcd_valid(),
`endif
    .o_at_limit (at_limit)
  );

`ifdef COUNTER_BCD_EN
  logic        b_run, b_load;
  logic [13:0] b_ldata;
  logic [13:0] b_count;
  logic [15:0] b_bcd;
  logic        b_valid;
  logic        b_tick, b_wrap, b_lim;

  updown_counter_tick #(
    .TICK_DIV (1),
    .MAX_COUNT(9999)
  ) dut_bcd (
    .clk        (clk),
    .reset      (rst_n),
    .i_run      (b_run),
    .i_clear    (1'b0),
    .i_up       (1'b1),
    .i_sat      (1'b0),
    .i_load     (b_load),
    .i_load_data(b_ldata),
    .o_count    (b_count),
    .o_tick     (b_tick),
    .o_wrap     (b_wrap),
    .o_bcd      (b_bcd),
    .o_bcd_valid(b_valid),
    .o_at_limit (b_lim)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic cyc(input logic r, input logic c, input logic u, input logic s,
                     input logic l, input logic [3:0] d);
    exp_t e;
    exp_t got;
    run = r; clear = c; up = u; sat = s; load = l; ldata = d;
    #1;
    check("at_limit", at_limit, (u && m_count == MAXC) || (!u && m_count == 0));
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (c) begin
      m_pre = 0;
      m_count = 0;
    end else if (l) begin
      m_count = (d > MAXC) ? MAXC : int'(d);
      m_pre = 0;
    end else if (r) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        e.tick = 1'b1;
        if (u) begin
          if (m_count < MAXC) m_count = m_count + 1;
          else if (!s) begin m_count = 0; e.wrap = 1'b1; end
        end else begin
          if (m_count > 0) m_count = m_count - 1;
          else if (!s) begin m_count = MAXC; e.wrap = 1'b1; end
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    e.count = 4'(m_count);
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("count", count, got.count);
    check("tick", tick, got.tick);
    check("wrap", wrap, got.wrap);
    if (tick === 1'b1) n_tick_seen++;
    if (wrap === 1'b1) n_wrap_seen++;
  endtask

  initial begin
    int first;
    int cnt_at_first;
    n_checks = 0;
    n_err = 0;
    m_pre = 0;
    m_count = 0;
    run = 0; clear = 0; up = 1; sat = 0; load = 0; ldata = '0;
`ifdef COUNTER_BCD_EN
    b_run = 0; b_load = 0; b_ldata = '0;
`endif
    rst_n = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
`ifdef COUNTER_BCD_EN
    check("rst_bcd", b_bcd, 0);
    check("rst_bcd_valid", b_valid, 1);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: run up to 5, then asynchronous reset between edges
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0, 0, 0);
    check("pre_reset_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_wrap", wrap, 0);
    m_pre = 0;
    m_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    first = -1;
    cnt_at_first = -1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 1, 0, 0, 0);
      if (tick === 1'b1) begin
        first = i;
        cnt_at_first = int'(count);
        break;
      end
    end
    check("first_tick_cycle", first, 4);
    check("first_tick_count", cnt_at_first, 1);

    // 2: up, wrap, 10 steps from 0
    cyc(0, 1, 1, 0, 0, 0);
    n_tick_seen = 0;
    n_wrap_seen = 0;
    for (int i = 0; i < 10 * TD; i++) cyc(1, 0, 1, 0, 0, 0);
    check("wrap_ticks", n_tick_seen, 10);
    check("wrap_wraps", n_wrap_seen, 1);
    check("wrap_end_count", count, 0);

    // 3: down, saturate from 2, then one wrapping step
    cyc(0, 0, 0, 1, 1, 4'd2);
    n_tick_seen = 0;
    n_wrap_seen = 0;
    for (int i = 0; i < 4 * TD; i++) cyc(1, 0, 0, 1, 0, 0);
    check("sat_ticks", n_tick_seen, 4);
    check("sat_wraps", n_wrap_seen, 0);
    check("sat_count", count, 0);
    for (int i = 0; i < TD; i++) cyc(1, 0, 0, 0, 0, 0);
    check("down_wrap_count", count, 9);
    check("down_wrap_wraps", n_wrap_seen, 1);

    // 4: pause the prescaler at 2 for 7 cycles
    cyc(0, 0, 0, 0, 1, 4'd5);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0);
    check("pause_count", count, 5);
    cyc(1, 0, 0, 0, 0, 0);
    check("resume_no_tick", tick, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("resume_tick", tick, 1);
    check("resume_count", count, 4);

    // 5: clear beats load; load clamps; load beats a coincident step
    cyc(0, 1, 0, 0, 1, 4'd7);
    check("clear_load_count", count, 0);
    cyc(0, 0, 1, 1, 1, 4'd15);
    check("clamp_count", count, 9);
    for (int i = 0; i < TD - 1; i++) cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 1, 4'd3);
    check("load_step_count", count, 3);
    check("load_step_tick", tick, 0);
    for (int i = 0; i < TD; i++) cyc(1, 0, 1, 1, 0, 0);
    check("post_load_count", count, 4);

`ifdef COUNTER_BCD_EN
    // 6: BCD conversion after load and after a burst of steps
    run = 0;
    b_ldata = 14'd1234;
    b_load = 1'b1;
    @(posedge clk);
    #1;
    b_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (b_valid === 1'b1 && b_bcd === 16'h1234) break;
      @(posedge clk);
      #1;
    end
    check("bcd_load_value", b_bcd, 16'h1234);
    check("bcd_load_valid", b_valid, 1);
    b_run = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) check("bcd_busy_valid", b_valid, 0);
    end
    b_run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    check("bcd_final_count", b_count, 1239);
    check("bcd_final_value", b_bcd, 16'h1239);
    check("bcd_final_valid", b_valid, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_tick.md
Name: updown_counter_tick

Overview:
Parametrised successor to the fixed 0..9999 run/clear counter. Single clock domain. A built-in prescaler tick-enable replaces the gated clock and divided-clock scheme. Adds up/down direction, wrap or saturate mode, synchronous load, and step/wrap status pulses. Its output feeds fnd_controller count_data, or a wider display path.

Parameters:
TICK_DIV, 1_000_000, clk cycles per count step (100 MHz -> 100 Hz); must be >= 1
MAX_COUNT, 9999, terminal value; count range is 0..MAX_COUNT
W (localparam), $clog2(MAX_COUNT+1), count width; 14 at default

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_run  in  1  1 = prescaler advances; 0 = hold everything
i_clear  in  1  synchronous clear of count and prescaler
i_up  in  1  1 = count up, 0 = count down
i_sat  in  1  0 = wrap at limits, 1 = saturate at limits
i_load  in  1  synchronous load strobe
i_load_data  in  W  load value
o_count  out  W  current count
o_tick  out  1  one-cycle pulse, registered; high in the cycle o_count shows a newly stepped value
o_wrap  out  1  one-cycle pulse, registered; high in the cycle o_count shows a wrapped value
o_at_limit  out  1  combinational level: (i_up && o_count==MAX_COUNT) || (!i_up && o_count==0)

Behaviour:
- reset low: prescaler=0, o_count=0, o_tick=0, o_wrap=0, immediately; no clk needed.
- Priority per clk edge: reset > i_clear > i_load > step.
- i_clear: prescaler=0, o_count=0, o_tick=0, o_wrap=0 on the next edge; applies regardless of i_run.
- i_load: o_count = (i_load_data > MAX_COUNT) ? MAX_COUNT : i_load_data; prescaler=0; no o_tick/o_wrap.
- Prescaler: counts 0..TICK_DIV-1 only while i_run=1, and holds its value while i_run=0. When prescaler==TICK_DIV-1 and i_run=1, a step occurs and prescaler returns to 0. With TICK_DIV=1, a step occurs every i_run cycle.
- Step, up, count < MAX_COUNT: count+1.
- Step, up, count == MAX_COUNT: i_sat=0 gives 0 and o_wrap; i_sat=1 holds MAX_COUNT with no o_wrap.
- Step, down, count > 0: count-1.
- Step, down, count == 0: i_sat=0 gives MAX_COUNT and o_wrap; i_sat=1 holds 0 with no o_wrap.
- o_tick pulses on every step, including a saturated hold.
- i_up and i_sat are sampled at the step edge only; changing them between steps is legal.
- Simultaneous clear and load: clear wins. Simultaneous load and step: load wins, and no pulse is issued.
- Step latency: count update and o_tick/o_wrap become visible 1 cycle after the edge where prescaler==TICK_DIV-1.
- No gated clocks; all flops sit on clk.

Optional Feature:
Macro COUNTER_BCD_EN.
- Defined: adds ports o_bcd [4*D-1:0] and o_bcd_valid, where D = decimal digits of MAX_COUNT (4 at default).
- Conversion: sequential shift-add-3, W cycles, restarted on every o_count change. A change while a conversion is busy aborts it and restarts.
- o_bcd_valid drops the cycle after a change and rises when the result is written. o_bcd holds the last completed result.
- After reset, o_bcd=0 and o_bcd_valid=1.
- Undefined: these ports and their logic are absent; the core behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - function f_digits(max) returning the decimal digit count
  - constants MODE_WRAP=1'b0 and MODE_SAT=1'b1
  - constant DIR_UP=1'b1
- One sub-module, cnt_tick_gen (parameter TICK_DIV; ports clk, reset, i_run, i_clear, o_step). Its i_clear port is driven with i_clear|i_load.
- The BCD converter stays inline under the macro guard.

Test Plan:
(bench params: TICK_DIV=4, MAX_COUNT=9)
1. Reset mid-run at count 5 -> o_count=0 and pulses=0 without waiting for a clk edge; after release with i_run=1, up, first o_tick 4 cycles later with o_count=1.
2. Up, wrap, from 0 for 10 steps -> 1..9 then 0; o_wrap high only with the 0; o_tick on all 10; o_at_limit high while count=9.
3. Down, saturate, load 2 then 4 steps -> 1, 0, 0, 0; o_tick each step, o_wrap never; then i_sat=0 for one step -> 9 with o_wrap.
4. i_run toggled 0 for 7 cycles at prescaler=2 -> count frozen; step arrives 2 cycles (prescaler 2→3) after i_run returns to 1.
5. Same-cycle i_clear+i_load(7) -> count 0; i_load 15 -> count 9 (clamped), no o_tick; load coincident with step -> loaded value, no pulse.
6. COUNTER_BCD_EN, MAX_COUNT=9999, TICK_DIV=1, load 1234 -> o_bcd=16'h1234 with o_bcd_valid after ≤ W+2 cycles; back-to-back steps -> o_bcd_valid stays low until the steps stop, then a final correct result.
